stage3_mem_lsu: RTL and testbench

- Load/store unit in the memory stage of the 3-stage pipeline; consumes memory-access fields of the execute→memory pipeline register (dren, dwen, address, store data, load_type).
- Drives the data-bus request handshake, generates byte enables and store-data lane replication, and sign/zero-extends load data.
- Detects misaligned accesses and bus timeouts; raises a stall to the hazard unit while an access is outstanding.

---
 rtl/stage3_mem_lsu.sv | 192 +++++++++++++++++++
 tb/tb_stage3_mem_lsu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stage3_mem_lsu.sv
// Memory-stage load/store unit: drives the data-bus handshake, lane-aligns store data,
// extends load data and flags misaligned accesses and bus timeouts.
module stage3_mem_lsu #(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        valid,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  load_type,
  input  logic        advance,
  input  logic        flush,
  output logic        dbus_ren,
  output logic        dbus_wen,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_byte_en,
  input  logic        dbus_busy,
  input  logic [31:0] dbus_rdata,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        mal_load,
  output logic        mal_store,
  output logic        fault_load,
  output logic        fault_store,
  output logic        lsu_done
);

  localparam int unsigned LIMIT_M1 = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       ltype_q, ltype_d;
  logic             ld_q, ld_d;
  logic             fault_q, fault_d;
  logic [29:0]      waddr_q, waddr_d;
  logic [31:0]      wdat_q, wdat_d;
  logic [3:0]       be_q, be_d;

  logic        is_ld_c, is_st_c, mis_c, start_c, req_live_c, timeout_c;
  logic [3:0]  be_c;
  logic [31:0] rep_c, sh_c, ext_c;

  // Request decode: size, misalignment, byte lanes and replicated store data.
  always_comb begin
    is_ld_c = dren;
    is_st_c = dwen & ~dren;
    case (load_type[1:0])
      2'b00: begin
        mis_c = 1'b0;
        be_c  = 4'b0001 << addr[1:0];
        rep_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        mis_c = addr[0];
        be_c  = 4'b0011 << {addr[1], 1'b0};
        rep_c = {2{wdata[15:0]}};
      end
      default: begin
        mis_c = |addr[1:0];
        be_c  = 4'b1111;
        rep_c = wdata;
      end
    endcase
    start_c    = valid & (dren | dwen) & ~mis_c & ~flush & (state_q == IDLE);
    req_live_c = (state_q == ACCESS) || (state_q == DRAIN);
    timeout_c  = (WAIT_LIMIT != 0) && (cnt_q >= CNT_W'(LIMIT_M1));
  end

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    off_d   = off_q;
    ltype_d = ltype_q;
    ld_d    = ld_q;
    fault_d = fault_q;
    waddr_d = waddr_q;
    wdat_d  = wdat_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          off_d   = addr[1:0];
          ltype_d = load_type;
          ld_d    = is_ld_c;
          waddr_d = addr[31:2];
          wdat_d  = rep_c;
          be_d    = be_c;
          fault_d = 1'b0;
          if (!dbus_busy) begin
            rdata_d = dbus_rdata;
            cnt_d   = '0;
            state_d = COMPLETE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = dbus_busy ? DRAIN : IDLE;
        end else if (!dbus_busy) begin
          rdata_d = dbus_rdata;
          cnt_d   = '0;
          state_d = COMPLETE;
        end else if (timeout_c) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMPLETE: begin
        cnt_d = '0;
        if (advance || flush) state_d = IDLE;
      end
      DRAIN: begin
        // The bus transfer cannot be abandoned; wait it out silently.
        if (!dbus_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      ltype_q <= '0;
      ld_q    <= 1'b0;
      fault_q <= 1'b0;
      waddr_q <= '0;
      wdat_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      ltype_q <= ltype_d;
      ld_q    <= ld_d;
      fault_q <= fault_d;
      waddr_q <= waddr_d;
      wdat_q  <= wdat_d;
      be_q    <= be_d;
    end
  end

  // Load extraction from the captured word and offset.
  always_comb begin
    sh_c = rdata_q >> {off_q, 3'b000};
    case (ltype_q)
      3'b000:  ext_c = {{24{sh_c[7]}}, sh_c[7:0]};
      3'b001:  ext_c = {{16{sh_c[15]}}, sh_c[15:0]};
      3'b100:  ext_c = {24'h0, sh_c[7:0]};
      3'b101:  ext_c = {16'h0, sh_c[15:0]};
      default: ext_c = sh_c;
    endcase
  end

  // Bus request is live combinationally on start, then held from captured copies.
  always_comb begin
    dbus_ren     = start_c ? is_ld_c : (req_live_c & ld_q);
    dbus_wen     = start_c ? is_st_c : (req_live_c & ~ld_q);
    dbus_addr    = start_c ? {addr[31:2], 2'b00} : (req_live_c ? {waddr_q, 2'b00} : 32'h0);
    dbus_byte_en = start_c ? be_c : (req_live_c ? be_q : 4'h0);
    dbus_wdata   = (start_c & is_st_c) ? rep_c : ((req_live_c & ~ld_q) ? wdat_q : 32'h0);
    lsu_stall    = start_c | (state_q == ACCESS);
    lsu_done     = (state_q == COMPLETE);
    load_data    = (lsu_done & ld_q & ~fault_q) ? ext_c : 32'h0;
    fault_load   = lsu_done & fault_q & ld_q;
    fault_store  = lsu_done & fault_q & ~ld_q;
    mal_load     = valid & ~flush & dren & mis_c;
    mal_store    = valid & ~flush & dwen & ~dren & mis_c;
  end

endmodule

// File: tb/tb_stage3_mem_lsu.sv
// Bench for stage3_mem_lsu: directed scenarios plus randomized accesses against a lane/extension model.
module tb_stage3_mem_lsu;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        valid, dren, dwen, advance, flush, dbus_busy;
  logic [31:0] addr, wdata, dbus_rdata;
  logic [2:0]  load_type;
  logic        dbus_ren, dbus_wen, lsu_stall, mal_load, mal_store, fault_load, fault_store, lsu_done;
  logic [31:0] dbus_addr, dbus_wdata, load_data;
  logic [3:0]  dbus_byte_en;

  int nchecks = 0;
  int nerr    = 0;

  stage3_mem_lsu #(.WAIT_LIMIT(4), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .valid(valid), .dren(dren), .dwen(dwen), .addr(addr),
    .wdata(wdata), .load_type(load_type), .advance(advance), .flush(flush),
    .dbus_ren(dbus_ren), .dbus_wen(dbus_wen), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_byte_en(dbus_byte_en), .dbus_busy(dbus_busy), .dbus_rdata(dbus_rdata),
    .lsu_stall(lsu_stall), .load_data(load_data), .mal_load(mal_load), .mal_store(mal_store),
    .fault_load(fault_load), .fault_store(fault_store), .lsu_done(lsu_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size from funct3: 0 byte, 1 half, 2 word.
  function automatic int size_of(input logic [2:0] lt);
    return (lt[1:0] == 2'b00) ? 0 : (lt[1:0] == 2'b01) ? 1 : 2;
  endfunction

  function automatic logic [3:0] exp_be(input int sz, input int off);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Each byte lane carries the store datum's byte (lane mod access width).
  function automatic logic [31:0] exp_wd(input int sz, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] lt, input int off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = (off <= 2) ? rd[8*off +: 16] : 16'h0;
    case (lt)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One access: busy = number of busy cycles the bus reports, hold = extra COMPLETE cycles.
  task automatic txn(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] lt, input int busy, input int hold, input logic [31:0] rd);
    int sz, off, n;
    bit is_ld, mis, flt;
    sz    = size_of(lt);
    off   = int'(a[1:0]);
    is_ld = ld;
    mis   = (sz == 1 && a[0]) || (sz == 2 && off != 0);
    valid = 1'b1; dren = ld; dwen = st; addr = a; wdata = wd; load_type = lt;
    advance = 1'b0; flush = 1'b0; dbus_busy = 1'b0;
    if (mis) begin
      @(negedge CLK);
      chk("mal_load", 32'(mal_load), 32'(ld));
      chk("mal_store", 32'(mal_store), 32'(st & ~ld));
      chk("mis_noreq", 32'(dbus_ren | dbus_wen), 32'h0);
      chk("mis_stall", 32'(lsu_stall), 32'h0);
      next_cycle();
      valid = 1'b0; dren = 1'b0; dwen = 1'b0;
      return;
    end
    flt = (busy >= 4);
    n   = flt ? 4 : busy + 1;
    for (int k = 0; k < n; k++) begin
      dbus_busy  = (k < busy);
      dbus_rdata = (k < busy) ? $urandom : rd;
      @(negedge CLK);
      chk("req_ren", 32'(dbus_ren), 32'(is_ld));
      chk("req_wen", 32'(dbus_wen), 32'(!is_ld));
      chk("req_addr", dbus_addr, {a[31:2], 2'b00});
      chk("req_be", 32'(dbus_byte_en), 32'(exp_be(sz, off)));
      chk("req_wdata", dbus_wdata, is_ld ? 32'h0 : exp_wd(sz, wd));
      chk("req_stall", 32'(lsu_stall), 32'h1);
      chk("req_done", 32'(lsu_done), 32'h0);
      next_cycle();
    end
    dbus_busy  = 1'b0;
    dbus_rdata = $urandom;
    for (int h = 0; h <= hold; h++) begin
      advance = (h == hold);
      @(negedge CLK);
      chk("cmp_done", 32'(lsu_done), 32'h1);
      chk("cmp_stall", 32'(lsu_stall), 32'h0);
      chk("cmp_noreq", 32'(dbus_ren | dbus_wen), 32'h0);
      chk("cmp_data", load_data, (is_ld && !flt) ? exp_ld(lt, off, rd) : 32'h0);
      chk("cmp_fault_ld", 32'(fault_load), 32'(is_ld & flt));
      chk("cmp_fault_st", 32'(fault_store), 32'(!is_ld & flt));
      next_cycle();
    end
    valid = 1'b0; dren = 1'b0; dwen = 1'b0; advance = 1'b0;
    @(negedge CLK);
    chk("post_done", 32'(lsu_done), 32'h0);
    chk("post_stall", 32'(lsu_stall), 32'h0);
    next_cycle();
  endtask

  initial begin
    logic [2:0] lt;
    logic [31:0] a;
    int op;
    nRST = 1'b0; valid = 1'b0; dren = 1'b0; dwen = 1'b0; addr = '0; wdata = '0;
    load_type = '0; advance = 1'b0; flush = 1'b0; dbus_busy = 1'b0; dbus_rdata = '0;
    #2;
    chk("rst_ren", 32'(dbus_ren), 32'h0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_stall", 32'(lsu_stall), 32'h0);
    chk("rst_done", 32'(lsu_done), 32'h0);
    chk("rst_data", load_data, 32'h0);
    #10 nRST = 1'b1;
    next_cycle();

    txn(1, 0, 32'h100, 32'h0, 3'b010, 2, 0, 32'hDEADBEEF);
    txn(1, 0, 32'h103, 32'h0, 3'b000, 0, 0, 32'h80FF_0000);
    txn(1, 0, 32'h103, 32'h0, 3'b100, 0, 0, 32'h80FF_0000);
    txn(0, 1, 32'h202, 32'h1234ABCD, 3'b001, 0, 0, 32'h0);
    txn(1, 0, 32'h101, 32'h0, 3'b010, 0, 0, 32'h0);
    txn(0, 1, 32'h3, 32'h55, 3'b001, 0, 0, 32'h0);
    txn(0, 1, 32'h40, 32'hCAFEF00D, 3'b010, 100, 1, 32'h0);
    txn(1, 0, 32'h82, 32'h0, 3'b101, 1, 3, 32'hBEEF_1234);
    txn(1, 1, 32'h84, 32'h0, 3'b010, 0, 0, 32'h0BAD_F00D);

    // Flush while the bus is busy: request held through drain, no completion.
    valid = 1'b1; dren = 1'b1; dwen = 1'b0; addr = 32'h400; load_type = 3'b010; dbus_busy = 1'b1;
    @(negedge CLK);
    chk("fl_start_ren", 32'(dbus_ren), 32'h1);
    next_cycle();
    flush = 1'b1;
    @(negedge CLK);
    chk("fl_acc_ren", 32'(dbus_ren), 32'h1);
    chk("fl_acc_stall", 32'(lsu_stall), 32'h1);
    next_cycle();
    flush = 1'b0; valid = 1'b0; dren = 1'b0; addr = 32'hFFFF_FFFC;
    for (int d = 0; d < 4; d++) begin
      dbus_busy = (d < 3);
      @(negedge CLK);
      chk("dr_ren", 32'(dbus_ren), 32'h1);
      chk("dr_addr", dbus_addr, 32'h400);
      chk("dr_stall", 32'(lsu_stall), 32'h0);
      chk("dr_done", 32'(lsu_done), 32'h0);
      next_cycle();
    end
    dbus_busy = 1'b0;
    @(negedge CLK);
    chk("dr_idle_ren", 32'(dbus_ren), 32'h0);
    chk("dr_idle_done", 32'(lsu_done), 32'h0);
    next_cycle();

    // Reset in the middle of an access drops the request at once.
    valid = 1'b1; dwen = 1'b1; addr = 32'h10; load_type = 3'b010; wdata = 32'h1; dbus_busy = 1'b1;
    @(negedge CLK);
    chk("rm_start_wen", 32'(dbus_wen), 32'h1);
    next_cycle();
    valid = 1'b0; dwen = 1'b0;
    @(negedge CLK);
    chk("rm_acc_wen", 32'(dbus_wen), 32'h1);
    nRST = 1'b0;
    #1;
    chk("rm_wen", 32'(dbus_wen), 32'h0);
    chk("rm_stall", 32'(lsu_stall), 32'h0);
    next_cycle();
    nRST = 1'b1; dbus_busy = 1'b0;
    next_cycle();

    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 2);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (op == 1) lt = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: lt = 3'b000; 1: lt = 3'b001; 2: lt = 3'b010; 3: lt = 3'b100;
          default: lt = 3'b101;
        endcase
      end
      txn(op != 1, op != 0, a, $urandom, lt, $urandom_range(0, 4), $urandom_range(0, 2), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
